// File: rtl/level_judge_pkg.sv
// Shared types and widths for the level referee (level_judge) and its scroll tracker.
package level_judge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PLAY = 3'd1,
        ST_HIT  = 3'd2,
        ST_WIN  = 3'd3,
        ST_LOSE = 3'd4
    } state_e;

    localparam int LIVES_W = 4;
    localparam int TIME_W  = 16;

    function automatic int scrolls_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/level_judge_scroll_tracker.sv
// Remembers which scrolls were already collected and counts only fresh hits,
// so a scroll held under the player is credited exactly once.
module scroll_tracker
    import level_judge_pkg::*;
#(
    parameter int NUM_SCROLLS = 24,
    parameter int CNT_W       = scrolls_w(NUM_SCROLLS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   enable,
    input  logic [NUM_SCROLLS-1:0] scroll_hit,
    output logic [CNT_W-1:0]       count_new,
    output logic [CNT_W-1:0]       scrolls_left
);

    logic [NUM_SCROLLS-1:0] mask_q, mask_d, new_hits;
    logic [CNT_W-1:0]       scrolls_q, scrolls_d;

    always_comb begin
        new_hits  = enable ? (scroll_hit & ~mask_q) : '0;
        count_new = '0;
        for (int i = 0; i < NUM_SCROLLS; i++) begin
            count_new = count_new + CNT_W'(new_hits[i]);
        end
        mask_d    = mask_q | new_hits;
        scrolls_d = scrolls_q - count_new;
        if (clear) begin
            mask_d    = '0;
            scrolls_d = CNT_W'(NUM_SCROLLS);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mask_q    <= '0;
            scrolls_q <= CNT_W'(NUM_SCROLLS);
        end else begin
            mask_q    <= mask_d;
            scrolls_q <= scrolls_d;
        end
    end

    assign scrolls_left = scrolls_q;

endmodule

// File: rtl/level_judge.sv
// Level referee feeding GameFSM: lives, countdown, invulnerability and win/lose pulses.
// Define LEVEL_JUDGE_BONUS_TIME_EN to credit BONUS_TICKS per collected scroll.
module level_judge
    import level_judge_pkg::*;
#(
    parameter int NUM_SCROLLS  = 24,
    parameter int LIVES        = 3,
    parameter int TIME_TICKS   = 3600,
    parameter int INVULN_TICKS = 60,
    parameter int BONUS_TICKS  = 120
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               tick,
    input  logic                               level_start,
    input  logic [NUM_SCROLLS-1:0]             scroll_hit,
    input  logic                               wall_hit,
    output logic                               level_passed,
    output logic                               lose,
    output logic [LIVES_W-1:0]                 lives_left,
    output logic [TIME_W-1:0]                  time_left,
    output logic [scrolls_w(NUM_SCROLLS)-1:0]  scrolls_left,
    output logic                               invuln,
    output logic [2:0]                         state_o
);

    localparam int CNT_W = scrolls_w(NUM_SCROLLS);

`ifdef LEVEL_JUDGE_BONUS_TIME_EN
    localparam int BONUS_PER = BONUS_TICKS;
`else
    localparam int BONUS_PER = BONUS_TICKS * 0;
`endif

    function automatic logic [TIME_W-1:0] sat_time(input logic [31:0] v);
        return (v > 32'(TIME_TICKS)) ? TIME_W'(TIME_TICKS) : v[TIME_W-1:0];
    endfunction

    state_e             state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [TIME_W-1:0]  time_q, time_d;
    logic [TIME_W-1:0]  inv_q, inv_d;
    logic               passed_q, passed_d;
    logic               lose_q, lose_d;
    logic               invuln_q, invuln_d;

    logic               active;
    logic [CNT_W-1:0]   count_new;
    logic [CNT_W-1:0]   scrolls_cnt;
    logic [TIME_W-1:0]  time_dec, time_nx;
    logic [31:0]        time_sum;
    logic               win_now, timer_lose, wall_in_play;

    assign active = (state_q == ST_PLAY) || (state_q == ST_HIT);

    scroll_tracker #(
        .NUM_SCROLLS (NUM_SCROLLS),
        .CNT_W       (CNT_W)
    ) u_tracker (
        .clk          (clk),
        .rst          (rst),
        .clear        (level_start),
        .enable       (active),
        .scroll_hit   (scroll_hit),
        .count_new    (count_new),
        .scrolls_left (scrolls_cnt)
    );

    // Bonus is added after the tick decrement so a same-cycle collect can rescue the final tick.
    always_comb begin
        time_dec     = (tick && time_q != '0) ? time_q - TIME_W'(1) : time_q;
        time_sum     = 32'(time_dec) + 32'(count_new) * 32'(BONUS_PER);
        time_nx      = sat_time(time_sum);
        win_now      = (count_new != '0) && (count_new == scrolls_cnt);
        timer_lose   = tick && (time_nx == '0);
        wall_in_play = wall_hit && (state_q == ST_PLAY);
    end

    always_comb begin
        state_d  = state_q;
        lives_d  = lives_q;
        time_d   = time_q;
        inv_d    = inv_q;
        passed_d = 1'b0;
        lose_d   = 1'b0;

        if (level_start) begin
            state_d = ST_PLAY;
            lives_d = LIVES_W'(LIVES);
            time_d  = TIME_W'(TIME_TICKS);
            inv_d   = '0;
        end else if (active) begin
            time_d = time_nx;
            if (win_now) begin
                state_d  = ST_WIN;
                passed_d = 1'b1;
            end else if (wall_in_play && lives_q == LIVES_W'(1)) begin
                lives_d = '0;
                state_d = ST_LOSE;
                lose_d  = 1'b1;
            end else if (timer_lose) begin
                state_d = ST_LOSE;
                lose_d  = 1'b1;
            end else if (wall_in_play) begin
                lives_d = lives_q - LIVES_W'(1);
                state_d = ST_HIT;
                inv_d   = TIME_W'(INVULN_TICKS);
            end else if (state_q == ST_HIT && tick) begin
                inv_d = inv_q - TIME_W'(1);
                if (inv_q <= TIME_W'(1)) begin
                    inv_d   = '0;
                    state_d = ST_PLAY;
                end
            end
        end

        invuln_d = (state_d == ST_HIT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            lives_q  <= LIVES_W'(LIVES);
            time_q   <= TIME_W'(TIME_TICKS);
            inv_q    <= '0;
            passed_q <= 1'b0;
            lose_q   <= 1'b0;
            invuln_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lives_q  <= lives_d;
            time_q   <= time_d;
            inv_q    <= inv_d;
            passed_q <= passed_d;
            lose_q   <= lose_d;
            invuln_q <= invuln_d;
        end
    end

    assign level_passed = passed_q;
    assign lose         = lose_q;
    assign lives_left   = lives_q;
    assign time_left    = time_q;
    assign scrolls_left = scrolls_cnt;
    assign invuln       = invuln_q;
    assign state_o      = state_q;

endmodule

// File: doc/level_judge.md
Name: level_judge

Overview:
- Referee stage directly upstream of GameFSM; drives its `levelPassed` and `lose` inputs.
- Consumes per-scroll and wall collision flags from the Scrolls/Obstacles/enableCompare path, plus the slow game tick.
- Tracks collected scrolls, remaining lives, post-hit invulnerability and a per-level countdown.
- Emits one-cycle win/lose pulses and HUD-ready status counters.

Parameters:
- NUM_SCROLLS, 24, number of collectible scroll objects (4x6 grid flattened).
- LIVES, 3, lives loaded at level start.
- TIME_TICKS, 3600, level duration in game ticks.
- INVULN_TICKS, 60, invulnerability window after a wall hit, in game ticks.
- BONUS_TICKS, 120, time added per collected scroll (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset; fixed by the codebase
- tick  in  1  one-clk-wide game tick pulse (BtnClk domain, already synchronised to clk)
- level_start  in  1  one-clk pulse from GameFSM: arm a new level
- scroll_hit  in  NUM_SCROLLS  level flags: player overlaps scroll i
- wall_hit  in  1  level flag: player overlaps any obstacle
- level_passed  out  1  one-clk pulse on entry to WIN
- lose  out  1  one-clk pulse on entry to LOSE
- lives_left  out  4  remaining lives
- time_left  out  16  remaining ticks
- scrolls_left  out  $clog2(NUM_SCROLLS+1)  uncollected scrolls
- invuln  out  1  high while in HIT (player blink)
- state_o  out  3  current FSM state code

Behaviour:
- All outputs are registered. An input sampled on cycle n is reflected on outputs at cycle n+1.
- Reset (rst=0 at a clk edge):
  - state IDLE; level_passed=0, lose=0, invuln=0.
  - lives_left=LIVES, time_left=TIME_TICKS, scrolls_left=NUM_SCROLLS.
  - collected mask cleared.
  - Reset mid-level aborts without any pulse.
- States: IDLE=0, PLAY=1, HIT=2, WIN=3, LOSE=4.
- level_start in any state: reload lives, time and scrolls, clear the mask, go to PLAY. This takes priority over every other event in that cycle.
- Scroll collection (PLAY or HIT only):
  - new = scroll_hit & ~mask; mask |= new.
  - scrolls_left -= popcount(new).
  - Several scrolls may be collected in one cycle. A held hit counts once.
- Timer: in PLAY or HIT, each tick decrements time_left. It never wraps below 0.
- Wall hit in PLAY with lives_left>1: lives_left-=1, go to HIT, load the invulnerability counter with INVULN_TICKS.
- Wall hit in PLAY with lives_left==1: lives_left=0, go to LOSE.
- HIT: wall_hit is ignored. The invulnerability counter decrements on tick; on reaching 0, go to PLAY.
- WIN when scrolls_left would become 0.
- LOSE when time_left would become 0 from a tick, or lives run out.
- Same-cycle priority: level_start > WIN > LOSE(lives) > LOSE(timer) > HIT entry.
- WIN/LOSE: pulse is high exactly the first cycle in the state. The state holds, with counters frozen, until level_start.
- IDLE: counters hold; hits and ticks are ignored.

Optional Feature:
- Macro: LEVEL_JUDGE_BONUS_TIME_EN.
- Defined: each newly collected scroll adds BONUS_TICKS to time_left, saturating at TIME_TICKS. The add is applied after the same-cycle tick decrement.
- Not defined: collection never changes time_left, and the BONUS_TICKS parameter is unused.

Decomposition:
- Package level_judge_pkg holds:
  - state enum and codes;
  - counter widths (LIVES_W=4, TIME_W=16);
  - helper function for the scrolls_left width.
- One sub-module, scroll_tracker, holds the collected mask register, new-hit masking and popcount. It outputs count_new and scrolls_left.
- The FSM and counters stay in level_judge.

Test Plan:
- Reset, then level_start -> state_o=1, lives_left=3, time_left=3600, scrolls_left=24, no pulses.
- Hold scroll_hit[5]=1 for 10 cycles, then raise scroll_hit[0] and scroll_hit[23] together -> scrolls_left 24→23 once, then 23→21 in a single cycle.
- Collect all 24 scrolls -> level_passed high for exactly 1 cycle, state_o=3. Counters then freeze despite further ticks and hits.
- Wall hit, then wall hit held through HIT -> lives_left 3→2, invuln=1 for 60 ticks, no second decrement. A third and fourth hit in PLAY give lives 1→0, lose pulse, state_o=4.
- TIME_TICKS=5 with 5 ticks -> time_left reaches 0 and lose pulses. Last scroll collected in the same cycle as the final tick -> level_passed, no lose.
- rst=0 asserted in HIT mid-window -> next cycle IDLE with all reset values and no pulse. With LEVEL_JUDGE_BONUS_TIME_EN defined, a collect at time_left=3500 gives 3600 (saturated).
